// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port BRAM.
// slave = arbiter side, master = requesters/memory side (testbench).
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 32
);
  logic          M0_REQ;
  logic          M0_WE;
  logic          M0_LAST;
  logic [AW-1:0] M0_ADDR;
  logic [DW-1:0] M0_WDATA;
  logic          M0_GNT;
  logic [DW-1:0] M0_RDATA;
  logic          M0_RVALID;

  logic          M1_REQ;
  logic          M1_WE;
  logic          M1_LAST;
  logic [AW-1:0] M1_ADDR;
  logic [DW-1:0] M1_WDATA;
  logic          M1_GNT;
  logic [DW-1:0] M1_RDATA;
  logic          M1_RVALID;

  logic          MEM_EN;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;

  modport slave (
    input  M0_REQ, M0_WE, M0_LAST, M0_ADDR, M0_WDATA,
    output M0_GNT, M0_RDATA, M0_RVALID,
    input  M1_REQ, M1_WE, M1_LAST, M1_ADDR, M1_WDATA,
    output M1_GNT, M1_RDATA, M1_RVALID,
    output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
    input  MEM_RDATA
  );

  modport master (
    output M0_REQ, M0_WE, M0_LAST, M0_ADDR, M0_WDATA,
    input  M0_GNT, M0_RDATA, M0_RVALID,
    output M1_REQ, M1_WE, M1_LAST, M1_ADDR, M1_WDATA,
    input  M1_GNT, M1_RDATA, M1_RVALID,
    input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
    output MEM_RDATA
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between M0 (USB) and M1 (test/DMA),
// with burst hold and forced hand-off after MAX_BURST beats. Optional stats: ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int unsigned MEM_SIZE  = 8192,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST_N,
`ifdef ARB_STATS_EN
  input  logic        STAT_CLR,
  output logic [31:0] STAT_BEAT0,
  output logic [31:0] STAT_BEAT1,
  output logic [15:0] STAT_FORCE,
`endif
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned AW = $clog2(MEM_SIZE / 4);
  localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rv_q, rv_d;
  logic [DW-1:0] rdata_q [2];

  logic [1:0]    req, we, last;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          own, beat_c, forced_c, rel_c;

  assign req      = {bus.M1_REQ, bus.M0_REQ};
  assign we       = {bus.M1_WE, bus.M0_WE};
  assign last     = {bus.M1_LAST, bus.M0_LAST};
  assign addr[0]  = bus.M0_ADDR;
  assign addr[1]  = bus.M1_ADDR;
  assign wdata[0] = bus.M0_WDATA;
  assign wdata[1] = bus.M1_WDATA;

  assign own    = (state_q == OWN1);
  assign beat_c = (state_q != IDLE) && req[own];

  // Grant FSM: pick by pointer from IDLE, release on LAST / REQ drop / burst cap.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    forced_c = 1'b0;
    rel_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req[0] && req[1]) state_d = ptr_q ? OWN1 : OWN0;
        else if (req[0])      state_d = OWN0;
        else if (req[1])      state_d = OWN1;
      end
      OWN0, OWN1: begin
        forced_c = beat_c && (cnt_q == CNT_MAX) && req[~own];
        rel_c    = !req[own] || (beat_c && last[own]) || forced_c;
        if (rel_c) begin
          state_d = req[~own] ? (own ? OWN0 : OWN1) : IDLE;
          ptr_d   = ~own;
        end
      end
      default: state_d = IDLE;
    endcase
    // Count saturates so a long solo burst is cut on its next beat once the other asks.
    if (state_d != state_q)                 cnt_d = '0;
    else if (beat_c && (cnt_q != CNT_MAX))  cnt_d = cnt_q + CW'(1);
  end

  // The read tag remembers which master issued the beat, so RVALID survives a hand-off.
  assign rv_d[0] = beat_c && !we[own] && !own;
  assign rv_d[1] = beat_c && !we[own] && own;

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      cnt_q      <= '0;
      rv_q       <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      if (rv_q[0]) rdata_q[0] <= bus.MEM_RDATA;
      if (rv_q[1]) rdata_q[1] <= bus.MEM_RDATA;
    end
  end

  assign bus.M0_GNT    = (state_q == OWN0);
  assign bus.M1_GNT    = (state_q == OWN1);
  assign bus.M0_RVALID = rv_q[0];
  assign bus.M1_RVALID = rv_q[1];
  assign bus.M0_RDATA  = rv_q[0] ? bus.MEM_RDATA : rdata_q[0];
  assign bus.M1_RDATA  = rv_q[1] ? bus.MEM_RDATA : rdata_q[1];

  assign bus.MEM_EN    = beat_c;
  assign bus.MEM_WE    = beat_c && we[own];
  assign bus.MEM_ADDR  = beat_c ? addr[own]  : '0;
  assign bus.MEM_WDATA = beat_c ? wdata[own] : '0;

`ifdef ARB_STATS_EN
  logic [31:0] beat0_q, beat0_d, beat1_q, beat1_d;
  logic [15:0] force_q, force_d;

  // Saturating counters; clear has priority over increment.
  always_comb begin
    beat0_d = beat0_q;
    beat1_d = beat1_q;
    force_d = force_q;
    if (STAT_CLR) begin
      beat0_d = '0;
      beat1_d = '0;
      force_d = '0;
    end else begin
      if (beat_c && !own && (beat0_q != '1)) beat0_d = beat0_q + 32'd1;
      if (beat_c && own && (beat1_q != '1))  beat1_d = beat1_q + 32'd1;
      if (forced_c && (force_q != '1))       force_d = force_q + 16'd1;
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      beat0_q <= '0;
      beat1_q <= '0;
      force_q <= '0;
    end else begin
      beat0_q <= beat0_d;
      beat1_q <= beat1_d;
      force_q <= force_d;
    end
  end

  assign STAT_BEAT0 = beat0_q;
  assign STAT_BEAT1 = beat1_q;
  assign STAT_FORCE = force_q;
`endif

endmodule
